// File: rtl/dcache_mem_responder_pkg.sv
// Shared data-cache definitions: line geometry and the memory responder state type.
package dcache_mem_responder_pkg;

    localparam int DCACHE_LINE_WIDTH  = 128;
    localparam int DCACHE_OFFSET_BITS = $clog2(DCACHE_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_ACK  = 2'd2
    } type_dmem_resp_states_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dcache_mem_responder_ram.sv
// Single-port line-wide backing store with a registered read port.
// The read register is cleared by reset so the responder's data output starts at zero;
// the array itself is never reset.
module dmem_line_ram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Array write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read; holds its value until the next read enable.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for dcache line reads/writes with fixed per-type latency,
// one-cycle ack and kill support. The RAM read is launched one cycle before ACK so
// the registered RAM output is valid exactly in the ack cycle.
module dcache_mem_responder
    import dcache_mem_responder_pkg::*;
#(
    parameter int LINE_WIDTH = DCACHE_LINE_WIDTH,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LINES  = 1024,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dcache2mem_req_i,
    input  logic                  dcache2mem_wr_i,
    input  logic                  dcache2mem_kill_i,
    input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
    output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
    output logic                  mem2dcache_ack_o
);

    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int IDX_BITS    = $clog2(MEM_LINES);
    localparam int CNT_W       = $clog2(max_int(RD_LATENCY, WR_LATENCY) + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LATENCY - 1);

    type_dmem_resp_states_e r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic                   r_wr;
    logic [IDX_BITS-1:0]    r_idx;
    logic [LINE_WIDTH-1:0]  r_data;

    logic [IDX_BITS-1:0]    w_req_idx;
    logic [CNT_W-1:0]       w_lat_last;
    logic                   w_load;
    logic                   w_ram_we;
    logic                   w_ram_re;
    logic [IDX_BITS-1:0]    w_ram_addr;
    logic                   w_unused_addr_bits;

    // Upper address bits alias onto the same lines; offset bits select bytes within a line.
    assign w_req_idx          = dcache2mem_addr_i[OFFSET_BITS +: IDX_BITS];
    assign w_unused_addr_bits = ^{dcache2mem_addr_i[ADDR_WIDTH-1:OFFSET_BITS+IDX_BITS],
                                  dcache2mem_addr_i[OFFSET_BITS-1:0]};
    assign w_lat_last         = dcache2mem_wr_i ? WR_LAST : RD_LAST;

    // Next-state, counter and RAM control.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_re     = 1'b0;
        w_ram_addr   = r_idx;
        case (r_state)
            DMEM_IDLE: begin
                if (dcache2mem_req_i && !dcache2mem_kill_i) begin
                    w_load     = 1'b1;
                    w_cnt_next = w_lat_last;
                    if (w_lat_last == '0) begin
                        // Single-cycle latency: request regs are not loaded yet, so read
                        // straight from the incoming address.
                        w_state_next = DMEM_ACK;
                        w_ram_re     = !dcache2mem_wr_i;
                        w_ram_addr   = w_req_idx;
                    end else begin
                        w_state_next = DMEM_BUSY;
                    end
                end
            end
            DMEM_BUSY: begin
                if (dcache2mem_kill_i) begin
                    w_state_next = DMEM_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = DMEM_ACK;
                        w_ram_re     = !r_wr;
                    end
                end
            end
            DMEM_ACK: begin
                // A kill in the ack cycle still lets the ack show, but the write is dropped.
                w_state_next = DMEM_IDLE;
                w_ram_we     = r_wr && !dcache2mem_kill_i && !rst;
            end
            default: begin
                w_state_next = DMEM_IDLE;
            end
        endcase
    end

    // State and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DMEM_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request capture; later changes on the request bus are ignored until IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr   <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_wr   <= dcache2mem_wr_i;
            r_idx  <= w_req_idx;
            r_data <= dcache2mem_data_i;
        end
    end

    dmem_line_ram #(
        .WIDTH (LINE_WIDTH),
        .DEPTH (MEM_LINES),
        .AW    (IDX_BITS)
    ) u_ram (
        .clk     (clk),
        .i_rst   (rst),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (r_data),
        .o_rdata (mem2dcache_data_o)
    );

    assign mem2dcache_ack_o = (r_state == DMEM_ACK);

endmodule
